// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_pkg;

  localparam int unsigned DefaultWidth = 1;
  localparam int unsigned MaxWidth     = 64;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder, the ripple element of full_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ cin;
  assign cout   = (a & b) | (cin & w_half);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with carry-in, registered sum/carry/overflow and a valid pulse.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;

  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;
  logic             r_valid;

  assign w_carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign w_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      // Results only load on accepted operations so idle inputs never reach the outputs.
      if (in_valid) begin
        r_sum      <= w_sum;
        r_c_out    <= w_carry[WIDTH];
        r_overflow <= w_overflow;
      end
    end
  end

  assign s         = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_overflow;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH 1, 8 and 16.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic        a1, b1, c1, v1, s1, co1, ov1, ov_v1;
  logic [7:0]  a8, b8, s8;
  logic        c8, v8, co8, ov8, ov_v8;
  logic [15:0] a16, b16, s16;
  logic        c16, v16, co16, ov16, ov_v16;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(v1),
    .s(s1), .c_out(co1), .overflow(ov1), .out_valid(ov_v1)
  );
  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .in_valid(v8),
    .s(s8), .c_out(co8), .overflow(ov8), .out_valid(ov_v8)
  );
  full_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16), .in_valid(v16),
    .s(s16), .c_out(co16), .overflow(ov16), .out_valid(ov_v16)
  );

  // Expected words are {overflow, c_out, s}.
  logic [2:0]  q1[$];
  logic [9:0]  q8[$];
  logic [17:0] q16[$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] Exp1 [8] = '{3'b000, 3'b101, 3'b001, 3'b010,
                                      3'b001, 3'b010, 3'b110, 3'b011};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop on every out_valid; a pulse with nothing expected is itself an error.
  always @(negedge clk) begin
    if (ov_v1) begin
      if (q1.size() == 0) check("w1_unexpected_valid", 64'd1, 64'd0);
      else check("w1_result", {61'd0, ov1, co1, s1}, {61'd0, q1.pop_front()});
    end
    if (ov_v8) begin
      if (q8.size() == 0) check("w8_unexpected_valid", 64'd1, 64'd0);
      else check("w8_result", {54'd0, ov8, co8, s8}, {54'd0, q8.pop_front()});
    end
    if (ov_v16) begin
      if (q16.size() == 0) check("w16_unexpected_valid", 64'd1, 64'd0);
      else check("w16_result", {46'd0, ov16, co16, s16}, {46'd0, q16.pop_front()});
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [9:0] exp);
    a8 = a; b8 = b; c8 = c; v8 = 1'b1;
    q8.push_back(exp);
  endtask

  initial begin
    logic [16:0] sum;
    int          accepted;
    {a1, b1, c1, v1} = '0;
    {a8, b8, c8, v8} = '0;
    {a16, b16, c16, v16} = '0;

    // Reset state, before any clock edge.
    #2;
    check("reset_w1", {60'd0, ov_v1, ov1, co1, s1}, 64'd0);
    check("reset_w8", {53'd0, ov_v8, ov8, co8, s8}, 64'd0);
    check("reset_w16", {45'd0, ov_v16, ov16, co16, s16}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep, back-to-back.
    for (int i = 0; i < 8; i++) begin
      tick();
      {a1, b1, c1} = 3'(i);
      v1 = 1'b1;
      q1.push_back(Exp1[i]);
    end
    tick();
    v1 = 1'b0;

    // WIDTH=8 boundary cases, back-to-back, then idle with all-ones inputs.
    op8(8'hFF, 8'h01, 1'b0, 10'h100);
    tick();
    op8(8'h7F, 8'h01, 1'b0, 10'h280);
    tick();
    op8(8'h80, 8'h80, 1'b1, 10'h301);
    tick();
    op8(8'h12, 8'h34, 1'b1, 10'h047);
    tick();
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b0;
    @(negedge clk);
    check("hold_valid_high", {63'd0, ov_v8}, 64'd1);
    check("hold_sum_first", {56'd0, s8}, 64'h47);
    @(negedge clk);
    check("hold_valid_low", {63'd0, ov_v8}, 64'd0);
    check("hold_sum", {54'd0, ov8, co8, s8}, 64'h047);

    // Asynchronous reset right after a capture discards the result.
    tick();
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sum", {56'd0, s8}, 64'd0);
    check("async_rst_cout", {63'd0, co8}, 64'd0);
    check("async_rst_valid", {63'd0, ov_v8}, 64'd0);
    check("async_rst_ovf", {63'd0, ov8}, 64'd0);
    tick();
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_stale_valid", {63'd0, ov_v8}, 64'd0);
    end

    // WIDTH=16 random stream; idle cycles carry random junk operands.
    accepted = 0;
    while (accepted < 10000) begin
      tick();
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      v16 = 1'($urandom);
      if (v16) begin
        sum = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
        q16.push_back({(a16[15] == b16[15]) && (sum[15] != a16[15]), sum});
        accepted++;
      end
    end
    tick();
    v16 = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_q1", 64'(q1.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);
    check("drain_q16", 64'(q16.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
